rtc_esclavo_bus: RTL and testbench

Synthesizable responder for the RTC parallel bus driven by Ruta_Control: it decodes the active-low CS/RD/WR/A_D strobes on the multiplexed DIR_DATO bus, latches addresses, accepts data writes, returns register contents on reads, and keeps BCD time/date plus a countdown timer. It replaces the external RTC chip in board bring-up and system simulation, sitting on the same DIR_DATO net as Ruta_Control.

---
 rtl/rtc_esclavo_bus_if.sv | 12 +
 rtl/rtc_esclavo_bus.sv | 263 ++++++++++++++++++++++++++
 tb/tb_rtc_esclavo_bus.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_esclavo_bus_if.sv
// Strobe bundle of the RTC parallel bus (CS/RD/WR/A_D, all active low except A_D).
// The multiplexed DIR_DATO net stays a plain inout on the responder so the
// tristate resolves on an ordinary wire shared with the controller.
interface rtc_esclavo_bus_if;
    logic CS;
    logic RD;
    logic WR;
    logic A_D;

    modport master (output CS, output RD, output WR, output A_D);
    modport slave  (input  CS, input  RD, input  WR, input  A_D);
endinterface

// File: rtl/rtc_esclavo_bus.sv
// RTC bus responder: decodes the multiplexed address/data strobes, holds BCD
// time/date, a BCD countdown timer and a sticky "timer done" status bit.
module rtc_esclavo_bus (
    input  logic             reloj,
    input  logic             resetM,
    rtc_esclavo_bus_if.slave bus,
    inout  wire  [7:0]       DIR_DATO,
    input  logic             tick_1hz,
    output logic             irq_n
);
    localparam logic [7:0] A_STATUS = 8'h00;
    localparam logic [7:0] A_SEG    = 8'h21;
    localparam logic [7:0] A_MIN    = 8'h22;
    localparam logic [7:0] A_HORA   = 8'h23;
    localparam logic [7:0] A_DIA    = 8'h24;
    localparam logic [7:0] A_MES    = 8'h25;
    localparam logic [7:0] A_ANO    = 8'h26;
    localparam logic [7:0] A_TSEG   = 8'h41;
    localparam logic [7:0] A_TMIN   = 8'h42;
    localparam logic [7:0] A_THORA  = 8'h43;

    // Sampled pins and previous-cycle copies for edge detection
    logic       s_cs_q, s_rd_q, s_wr_q, s_ad_q;
    logic [7:0] s_dat_q;
    logic       p_cs_q, p_wr_q;
    // Bus-side state
    logic       armed_q, armed_d;
    logic       cap_vld_q, cap_vld_d, cap_ad_q, cap_ad_d;
    logic [7:0] cap_dat_q, cap_dat_d;
    logic [7:0] ptr_q, ptr_d;
    logic       oe_q, oe_d;
    logic [7:0] dout_q, dout_d;
    // Time, date, timer and status
    logic [7:0] seg_q, seg_d, min_q, min_d, hora_q, hora_d;
    logic [7:0] dia_q, dia_d, mes_q, mes_d, ano_q, ano_d;
    logic [7:0] tseg_q, tseg_d, tmin_q, tmin_d, thora_q, thora_d;
    logic       st_q, st_d;
    logic       pend_q, pend_d;

    logic       wr_rise, wr_abort, commit, commit_addr, commit_data;
    logic       rd_first, rd_release, do_tick;
    logic [7:0] rd_val;
    logic [8:0] inc_seg, inc_min, inc_hora, inc_dia, inc_mes, inc_ano;
    logic [7:0] tseg_n, tmin_n, thora_n;
    logic       t_nz, tseg_borrow, tmin_borrow, t_done;

    // BCD increment returning {carry, next}; invalid digits count as at-maximum
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax,
                                           input logic [7:0] vmin);
        logic [8:0] r;
        if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v >= vmax))
            r = {1'b1, vmin};
        else if (v[3:0] == 4'd9)
            r = {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // BCD decrement without wrap; caller handles the 00 case
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0)
            r = {v[7:4] - 4'd1, 4'd9};
        else
            r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    // Last day of the month in BCD; year mod 4 from BCD digits: (2*hi + lo) mod 4
    function automatic logic [7:0] last_day(input logic [7:0] mes, input logic [7:0] ano);
        logic [1:0] m4;
        logic [7:0] r;
        m4 = {ano[4], 1'b0} + ano[1:0];
        case (mes)
            8'h02:                      r = (m4 == 2'd0) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
            default:                    r = 8'h31;
        endcase
        return r;
    endfunction

    assign wr_rise     = ~p_wr_q & s_wr_q;
    assign wr_abort    = ~p_cs_q & s_cs_q & ~s_wr_q;
    assign commit      = wr_rise & cap_vld_q;
    assign commit_addr = commit & ~cap_ad_q;
    assign commit_data = commit & cap_ad_q;
    assign rd_release  = s_cs_q | s_rd_q | ~s_wr_q;
    assign rd_first    = armed_q & ~s_cs_q & ~s_rd_q & s_wr_q & s_ad_q & ~oe_q;
    assign do_tick     = (tick_1hz | pend_q) & ~commit_data;
    assign pend_d      = commit_data & (tick_1hz | pend_q);
    assign armed_d     = armed_q | s_cs_q | (s_rd_q & s_wr_q);

    assign inc_seg  = bcd_inc(seg_q,  8'h59, 8'h00);
    assign inc_min  = bcd_inc(min_q,  8'h59, 8'h00);
    assign inc_hora = bcd_inc(hora_q, 8'h23, 8'h00);
    assign inc_dia  = bcd_inc(dia_q,  last_day(mes_q, ano_q), 8'h01);
    assign inc_mes  = bcd_inc(mes_q,  8'h12, 8'h01);
    assign inc_ano  = bcd_inc(ano_q,  8'h99, 8'h00);

    assign t_nz        = |{thora_q, tmin_q, tseg_q};
    assign tseg_borrow = (tseg_q == 8'h00);
    assign tmin_borrow = tseg_borrow & (tmin_q == 8'h00);
    assign tseg_n      = tseg_borrow ? 8'h59 : bcd_dec(tseg_q);
    assign tmin_n      = tseg_borrow ? ((tmin_q == 8'h00) ? 8'h59 : bcd_dec(tmin_q)) : tmin_q;
    assign thora_n     = tmin_borrow ? bcd_dec(thora_q) : thora_q;
    assign t_done      = (tseg_n == 8'h00) && (tmin_n == 8'h00) && (thora_n == 8'h00);

    assign DIR_DATO = oe_q ? dout_q : 8'hzz;
    assign irq_n    = ~st_q;

    // Register file read port addressed by the pointer
    always_comb begin
        rd_val = 8'h00;
        case (ptr_q)
            A_STATUS: rd_val = {7'd0, st_q};
            A_SEG:    rd_val = seg_q;
            A_MIN:    rd_val = min_q;
            A_HORA:   rd_val = hora_q;
            A_DIA:    rd_val = dia_q;
            A_MES:    rd_val = mes_q;
            A_ANO:    rd_val = ano_q;
            A_TSEG:   rd_val = tseg_q;
            A_TMIN:   rd_val = tmin_q;
            A_THORA:  rd_val = thora_q;
            default:  rd_val = 8'h00;
        endcase
    end

    // Bus decode: write capture/commit/abort, pointer, read snapshot and output enable
    always_comb begin
        cap_vld_d = cap_vld_q;
        cap_ad_d  = cap_ad_q;
        cap_dat_d = cap_dat_q;
        ptr_d     = ptr_q;
        oe_d      = oe_q;
        dout_d    = dout_q;
        if (armed_q && !s_cs_q && !s_wr_q) begin
            cap_vld_d = 1'b1;
            cap_ad_d  = s_ad_q;
            cap_dat_d = s_dat_q;
        end else if (wr_abort || wr_rise) begin
            cap_vld_d = 1'b0;
        end
        if (commit_addr)
            ptr_d = cap_dat_q;
        if (rd_release) begin
            oe_d = 1'b0;
        end else if (rd_first) begin
            oe_d   = 1'b1;
            dout_d = rd_val;
        end
    end

    // Data writes take priority; a coinciding tick is replayed next cycle
    always_comb begin
        seg_d   = seg_q;
        min_d   = min_q;
        hora_d  = hora_q;
        dia_d   = dia_q;
        mes_d   = mes_q;
        ano_d   = ano_q;
        tseg_d  = tseg_q;
        tmin_d  = tmin_q;
        thora_d = thora_q;
        st_d    = st_q;
        if (commit_data) begin
            case (ptr_q)
                A_STATUS: if (cap_dat_q[0]) st_d = 1'b0;
                A_SEG:    seg_d   = cap_dat_q;
                A_MIN:    min_d   = cap_dat_q;
                A_HORA:   hora_d  = cap_dat_q;
                A_DIA:    dia_d   = cap_dat_q;
                A_MES:    mes_d   = cap_dat_q;
                A_ANO:    ano_d   = cap_dat_q;
                A_TSEG:   tseg_d  = cap_dat_q;
                A_TMIN:   tmin_d  = cap_dat_q;
                A_THORA:  thora_d = cap_dat_q;
                default:  ;
            endcase
        end else if (do_tick) begin
            seg_d = inc_seg[7:0];
            if (inc_seg[8]) begin
                min_d = inc_min[7:0];
                if (inc_min[8]) begin
                    hora_d = inc_hora[7:0];
                    if (inc_hora[8]) begin
                        dia_d = inc_dia[7:0];
                        if (inc_dia[8]) begin
                            mes_d = inc_mes[7:0];
                            if (inc_mes[8])
                                ano_d = inc_ano[7:0];
                        end
                    end
                end
            end
            if (t_nz) begin
                tseg_d  = tseg_n;
                tmin_d  = tmin_n;
                thora_d = thora_n;
                if (t_done)
                    st_d = 1'b1;
            end
        end
    end

    // State registers; strobe samples reset to "active" so only a fresh high re-arms the bus
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            s_cs_q    <= 1'b0;
            s_rd_q    <= 1'b0;
            s_wr_q    <= 1'b0;
            s_ad_q    <= 1'b0;
            s_dat_q   <= 8'h00;
            p_cs_q    <= 1'b0;
            p_wr_q    <= 1'b0;
            armed_q   <= 1'b0;
            cap_vld_q <= 1'b0;
            cap_ad_q  <= 1'b0;
            cap_dat_q <= 8'h00;
            ptr_q     <= 8'h00;
            oe_q      <= 1'b0;
            dout_q    <= 8'h00;
            seg_q     <= 8'h00;
            min_q     <= 8'h00;
            hora_q    <= 8'h00;
            dia_q     <= 8'h01;
            mes_q     <= 8'h01;
            ano_q     <= 8'h00;
            tseg_q    <= 8'h00;
            tmin_q    <= 8'h00;
            thora_q   <= 8'h00;
            st_q      <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            s_cs_q    <= bus.CS;
            s_rd_q    <= bus.RD;
            s_wr_q    <= bus.WR;
            s_ad_q    <= bus.A_D;
            s_dat_q   <= DIR_DATO;
            p_cs_q    <= s_cs_q;
            p_wr_q    <= s_wr_q;
            armed_q   <= armed_d;
            cap_vld_q <= cap_vld_d;
            cap_ad_q  <= cap_ad_d;
            cap_dat_q <= cap_dat_d;
            ptr_q     <= ptr_d;
            oe_q      <= oe_d;
            dout_q    <= dout_d;
            seg_q     <= seg_d;
            min_q     <= min_d;
            hora_q    <= hora_d;
            dia_q     <= dia_d;
            mes_q     <= mes_d;
            ano_q     <= ano_d;
            tseg_q    <= tseg_d;
            tmin_q    <= tmin_d;
            thora_q   <= thora_d;
            st_q      <= st_d;
            pend_q    <= pend_d;
        end
    end
endmodule

// File: tb/tb_rtc_esclavo_bus.sv
// Bench for rtc_esclavo_bus: the bus net carries a pull-up, so a released
// DIR_DATO reads 8'hFF; no stored test value uses 8'hFF.
`timescale 1ns/1ps
module tb_rtc_esclavo_bus;
    logic       reloj = 1'b0;
    logic       resetM;
    logic       tick_1hz;
    wire        irq_n;
    wire  [7:0] DIR_DATO;
    logic       tb_oe;
    logic [7:0] tb_dat;
    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];

    rtc_esclavo_bus_if bus_if();

    assign DIR_DATO = tb_oe ? tb_dat : 8'hzz;
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pu
            pullup (DIR_DATO[gi]);
        end
    endgenerate

    rtc_esclavo_bus dut (
        .reloj    (reloj),
        .resetM   (resetM),
        .bus      (bus_if),
        .DIR_DATO (DIR_DATO),
        .tick_1hz (tick_1hz),
        .irq_n    (irq_n)
    );

    always #5 reloj = ~reloj;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge reloj);
    endtask

    // One write phase (A_D=0 address, A_D=1 data); optional tick on the commit cycle
    task automatic wr_phase(input logic ad, input logic [7:0] val, input bit tick_commit);
        @(negedge reloj);
        bus_if.A_D = ad; tb_dat = val; tb_oe = 1'b1; bus_if.CS = 1'b0; bus_if.WR = 1'b0;
        idle(2);
        bus_if.WR = 1'b1;
        @(negedge reloj);
        bus_if.CS = 1'b1; tb_oe = 1'b0;
        if (tick_commit) tick_1hz = 1'b1;
        @(negedge reloj);
        tick_1hz = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data, input bit tick_commit);
        wr_phase(1'b0, addr, 1'b0);
        wr_phase(1'b1, data, tick_commit);
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [7:0] got);
        wr_phase(1'b0, addr, 1'b0);
        @(negedge reloj);
        bus_if.A_D = 1'b1; bus_if.CS = 1'b0; bus_if.RD = 1'b0;
        idle(3);
        got = DIR_DATO;
        @(negedge reloj);
        bus_if.RD = 1'b1; bus_if.CS = 1'b1;
        idle(2);
    endtask

    task automatic tick();
        @(negedge reloj);
        tick_1hz = 1'b1;
        @(negedge reloj);
        tick_1hz = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] addrs [6] = '{8'h00, 8'h21, 8'h24, 8'h25, 8'h26, 8'h43};
        logic [7:0] exps  [6] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00};
        logic [7:0] got, e;
        total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL reset_irq got=%b exp=1", irq_n); end
        total++; if (DIR_DATO !== 8'hFF) begin bad++; $display("FAIL reset_bus got=%h exp=ff", DIR_DATO); end
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(exps[i]);
            bus_read(addrs[i], got);
            e = exp_q.pop_front();
            total++; if (got !== e) begin bad++; $display("FAIL reset_reg%h got=%h exp=%h", addrs[i], got, e); end
        end
    endtask

    task automatic test_write_read();
        logic [7:0] e;
        bus_write(8'h21, 8'h45, 1'b0);
        exp_q.push_back(8'h45);
        wr_phase(1'b0, 8'h21, 1'b0);
        @(negedge reloj);
        bus_if.A_D = 1'b1; bus_if.CS = 1'b0; bus_if.RD = 1'b0;
        @(negedge reloj);
        total++; if (DIR_DATO !== 8'hFF) begin bad++; $display("FAIL rd_early got=%h exp=ff", DIR_DATO); end
        @(negedge reloj);
        e = exp_q.pop_front();
        total++; if (DIR_DATO !== e) begin bad++; $display("FAIL rd_valid got=%h exp=%h", DIR_DATO, e); end
        @(negedge reloj);
        total++; if (DIR_DATO !== e) begin bad++; $display("FAIL rd_hold got=%h exp=%h", DIR_DATO, e); end
        @(negedge reloj);
        bus_if.RD = 1'b1; bus_if.CS = 1'b1;
        @(negedge reloj);
        total++; if (DIR_DATO !== e) begin bad++; $display("FAIL rd_tail got=%h exp=%h", DIR_DATO, e); end
        @(negedge reloj);
        total++; if (DIR_DATO !== 8'hFF) begin bad++; $display("FAIL rd_release got=%h exp=ff", DIR_DATO); end
    endtask

    task automatic set_clock(input logic [7:0] s, m, h, d, mo, y);
        bus_write(8'h21, s, 1'b0);  bus_write(8'h22, m, 1'b0);  bus_write(8'h23, h, 1'b0);
        bus_write(8'h24, d, 1'b0);  bus_write(8'h25, mo, 1'b0); bus_write(8'h26, y, 1'b0);
    endtask

    task automatic test_rollover();
        logic [7:0] exps [6] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
        logic [7:0] got, e;
        set_clock(8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99);
        tick();
        for (int i = 0; i < 6; i++) exp_q.push_back(exps[i]);
        for (int i = 0; i < 6; i++) begin
            bus_read(8'h21 + 8'(i), got);
            e = exp_q.pop_front();
            total++; if (got !== e) begin bad++; $display("FAIL rollover_%0d got=%h exp=%h", i, got, e); end
        end
    endtask

    task automatic test_leap();
        logic [7:0] got, e;
        set_clock(8'h59, 8'h59, 8'h23, 8'h28, 8'h02, 8'h24);
        tick();
        exp_q.push_back(8'h29); exp_q.push_back(8'h02);
        bus_read(8'h24, got); e = exp_q.pop_front();
        total++; if (got !== e) begin bad++; $display("FAIL leap_dia got=%h exp=%h", got, e); end
        bus_read(8'h25, got); e = exp_q.pop_front();
        total++; if (got !== e) begin bad++; $display("FAIL leap_mes got=%h exp=%h", got, e); end
        set_clock(8'h59, 8'h59, 8'h23, 8'h28, 8'h02, 8'h23);
        tick();
        exp_q.push_back(8'h01); exp_q.push_back(8'h03);
        bus_read(8'h24, got); e = exp_q.pop_front();
        total++; if (got !== e) begin bad++; $display("FAIL noleap_dia got=%h exp=%h", got, e); end
        bus_read(8'h25, got); e = exp_q.pop_front();
        total++; if (got !== e) begin bad++; $display("FAIL noleap_mes got=%h exp=%h", got, e); end
    endtask

    task automatic test_timer();
        logic [7:0] got, e;
        bus_write(8'h43, 8'h00, 1'b0); bus_write(8'h42, 8'h00, 1'b0); bus_write(8'h41, 8'h02, 1'b0);
        tick();
        total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL timer_irq_early got=%b exp=1", irq_n); end
        tick();
        total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL timer_irq_set got=%b exp=0", irq_n); end
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        bus_read(8'h41, got); e = exp_q.pop_front();
        total++; if (got !== e) begin bad++; $display("FAIL timer_seg got=%h exp=%h", got, e); end
        bus_read(8'h00, got); e = exp_q.pop_front();
        total++; if (got !== e) begin bad++; $display("FAIL status_set got=%h exp=%h", got, e); end
        bus_write(8'h00, 8'h01, 1'b0);
        total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL irq_clear got=%b exp=1", irq_n); end
        tick();
        total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL irq_no_reset got=%b exp=1", irq_n); end
        exp_q.push_back(8'h00);
        bus_read(8'h00, got); e = exp_q.pop_front();
        total++; if (got !== e) begin bad++; $display("FAIL status_clear got=%h exp=%h", got, e); end
        bus_write(8'h43, 8'h01, 1'b0); bus_write(8'h42, 8'h00, 1'b0); bus_write(8'h41, 8'h00, 1'b0);
        tick();
        exp_q.push_back(8'h00); exp_q.push_back(8'h59); exp_q.push_back(8'h59);
        for (int i = 0; i < 3; i++) begin
            bus_read(8'h43 - 8'(i), got); e = exp_q.pop_front();
            total++; if (got !== e) begin bad++; $display("FAIL timer_borrow_%0d got=%h exp=%h", i, got, e); end
        end
        total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL borrow_irq got=%b exp=1", irq_n); end
    endtask

    task automatic test_deferred_tick();
        logic [7:0] got, e;
        bus_write(8'h21, 8'h10, 1'b1);
        exp_q.push_back(8'h11); exp_q.push_back(8'h00);
        bus_read(8'h21, got); e = exp_q.pop_front();
        total++; if (got !== e) begin bad++; $display("FAIL deferred_tick got=%h exp=%h", got, e); end
        bus_read(8'h30, got); e = exp_q.pop_front();
        total++; if (got !== e) begin bad++; $display("FAIL unmapped got=%h exp=%h", got, e); end
    endtask

    task automatic test_invalid_bcd();
        logic [7:0] got, e;
        bus_write(8'h22, 8'h10, 1'b0); bus_write(8'h21, 8'h3C, 1'b0);
        tick();
        exp_q.push_back(8'h00); exp_q.push_back(8'h11);
        bus_read(8'h21, got); e = exp_q.pop_front();
        total++; if (got !== e) begin bad++; $display("FAIL invalid_seg got=%h exp=%h", got, e); end
        bus_read(8'h22, got); e = exp_q.pop_front();
        total++; if (got !== e) begin bad++; $display("FAIL invalid_min got=%h exp=%h", got, e); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] got, e;
        bus_write(8'h22, 8'h33, 1'b0);
        wr_phase(1'b0, 8'h22, 1'b0);
        @(negedge reloj);
        bus_if.A_D = 1'b1; bus_if.CS = 1'b0; bus_if.RD = 1'b0;
        idle(3);
        total++; if (DIR_DATO !== 8'h33) begin bad++; $display("FAIL pre_reset_drive got=%h exp=33", DIR_DATO); end
        resetM = 1'b1;
        #1;
        total++; if (DIR_DATO !== 8'hFF) begin bad++; $display("FAIL reset_release got=%h exp=ff", DIR_DATO); end
        @(negedge reloj);
        resetM = 1'b0;
        idle(3);
        total++; if (DIR_DATO !== 8'hFF) begin bad++; $display("FAIL stale_strobe got=%h exp=ff", DIR_DATO); end
        bus_if.RD = 1'b1; bus_if.CS = 1'b1;
        idle(2);
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        bus_read(8'h22, got); e = exp_q.pop_front();
        total++; if (got !== e) begin bad++; $display("FAIL rst_min got=%h exp=%h", got, e); end
        bus_read(8'h24, got); e = exp_q.pop_front();
        total++; if (got !== e) begin bad++; $display("FAIL rst_dia got=%h exp=%h", got, e); end
    endtask

    task automatic test_abort();
        logic [7:0] got, e;
        bus_write(8'h21, 8'h12, 1'b0);
        wr_phase(1'b0, 8'h21, 1'b0);
        @(negedge reloj);
        bus_if.A_D = 1'b1; tb_dat = 8'h34; tb_oe = 1'b1; bus_if.CS = 1'b0; bus_if.WR = 1'b0;
        idle(2);
        bus_if.CS = 1'b1;
        @(negedge reloj);
        bus_if.WR = 1'b1; tb_oe = 1'b0;
        idle(3);
        exp_q.push_back(8'h12);
        bus_read(8'h21, got); e = exp_q.pop_front();
        total++; if (got !== e) begin bad++; $display("FAIL abort got=%h exp=%h", got, e); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] addrs [4] = '{8'h24, 8'h25, 8'h26, 8'h42};
        logic [7:0] got, e, v;
        for (int i = 0; i < 4; i++) begin
            v = 8'($urandom_range(0, 8'h98));
            bus_write(addrs[i], v, 1'b0);
            exp_q.push_back(v);
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(addrs[i], got); e = exp_q.pop_front();
            total++; if (got !== e) begin bad++; $display("FAIL b2b_%h got=%h exp=%h", addrs[i], got, e); end
        end
    endtask

    initial begin
        resetM = 1'b1; tick_1hz = 1'b0; tb_oe = 1'b0; tb_dat = 8'h00;
        bus_if.CS = 1'b1; bus_if.RD = 1'b1; bus_if.WR = 1'b1; bus_if.A_D = 1'b0;
        idle(3);
        resetM = 1'b0;
        idle(2);
        test_reset();
        test_write_read();
        test_rollover();
        test_leap();
        test_timer();
        test_deferred_tick();
        test_invalid_bcd();
        test_abort();
        test_reset_mid_read();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
